// File: rtl/tcp_port_encap_pkg.sv
// Shared network-processor definitions: the packed IP header, the TCP port
// field size and the encapsulator state encoding.
package tcp_port_encap_pkg;

    localparam int TCP_PORT_BYTES = 4;
    localparam int IP_HDR_W       = 160;

    typedef struct packed {
        logic [3:0]  ip_version;
        logic [3:0]  ip_ihl;
        logic [5:0]  ip_dscp;
        logic [1:0]  ip_ecn;
        logic [15:0] ip_length;
        logic [15:0] ip_identification;
        logic [2:0]  ip_flags;
        logic [12:0] ip_fragment_offset;
        logic [7:0]  ip_ttl;
        logic [7:0]  ip_protocol;
        logic [15:0] ip_header_checksum;
        logic [31:0] ip_source_ip;
        logic [31:0] ip_dest_ip;
    } ip_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PORTS,
        ST_PAYLOAD
    } encap_state_e;

    // Port bytes go out big-endian: src high, src low, dest high, dest low.
    function automatic logic [7:0] port_byte(input logic [31:0] ports, input logic [1:0] idx);
        return ports[8*(3-idx) +: 8];
    endfunction

endpackage

// File: rtl/ip_intf.sv
// IP header + 8-bit AXIS payload bundle used between network-processor stages.
interface ip_intf;
    import tcp_port_encap_pkg::*;

    logic        ip_hdr_valid;
    logic        ip_hdr_ready;
    logic [47:0] eth_dest_mac;
    logic [47:0] eth_src_mac;
    logic [15:0] eth_type;
    ip_hdr_t     ip_hdr;
    logic [7:0]  ip_payload_axis_tdata;
    logic        ip_payload_axis_tvalid;
    logic        ip_payload_axis_tready;
    logic        ip_payload_axis_tlast;
    logic        ip_payload_axis_tuser;
    logic [7:0]  ip_payload_axis_tid;
    logic [7:0]  ip_payload_axis_tdest;

    modport MASTER (
        output ip_hdr_valid, eth_dest_mac, eth_src_mac, eth_type, ip_hdr,
        output ip_payload_axis_tdata, ip_payload_axis_tvalid, ip_payload_axis_tlast,
        output ip_payload_axis_tuser, ip_payload_axis_tid, ip_payload_axis_tdest,
        input  ip_hdr_ready, ip_payload_axis_tready
    );

    modport SLAVE (
        input  ip_hdr_valid, eth_dest_mac, eth_src_mac, eth_type, ip_hdr,
        input  ip_payload_axis_tdata, ip_payload_axis_tvalid, ip_payload_axis_tlast,
        input  ip_payload_axis_tuser, ip_payload_axis_tid, ip_payload_axis_tdest,
        output ip_hdr_ready, ip_payload_axis_tready
    );

endinterface

// File: rtl/tcp_port_encap_skidbuffer.sv
// Single-entry header holding register: accepts only when empty, drains on
// the downstream handshake.
module skidbuffer #(
    parameter int DW = 160
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic          full;
    logic [DW-1:0] data_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full   <= 1'b0;
            data_q <= '0;
        end else begin
            if (full && i_ready) begin
                full <= 1'b0;
            end
            if (i_valid && !full) begin
                full   <= 1'b1;
                data_q <= i_data;
            end
        end
    end

    assign o_ready = !full;
    assign o_valid = full;
    assign o_data  = data_q;

endmodule

// File: rtl/tcp_port_encap.sv
// TCP port encapsulator: prepends {src, dest} ports to the IP payload and
// grows ip_length by the four port bytes.
module tcp_port_encap
    import tcp_port_encap_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    ip_intf.SLAVE       s_ip,
    ip_intf.MASTER      m_ip,
    input  logic [15:0] i_tcp_src,
    input  logic [15:0] i_tcp_dest,
    output logic        o_busy
);

    localparam logic [1:0] LAST_PORT_IDX = 2'(TCP_PORT_BYTES - 1);

    encap_state_e state, state_next;
    logic [1:0]   port_cnt;
    logic [31:0]  port_q;
    logic         hdr_buf_ready;
    logic         hdr_out_valid;
    logic         hdr_fire;
    ip_hdr_t      hdr_adj;
    ip_hdr_t      hdr_out;

    always_comb begin
        hdr_adj           = s_ip.ip_hdr;
        hdr_adj.ip_length = s_ip.ip_hdr.ip_length + 16'd4;
    end

    assign hdr_fire = s_ip.ip_hdr_valid && s_ip.ip_hdr_ready;

    skidbuffer #(.DW(IP_HDR_W)) u_hdr_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (hdr_fire),
        .o_ready (hdr_buf_ready),
        .i_data  (hdr_adj),
        .o_valid (hdr_out_valid),
        .i_ready (m_ip.ip_hdr_ready),
        .o_data  (hdr_out)
    );

    assign m_ip.ip_hdr_valid          = hdr_out_valid;
    assign m_ip.ip_hdr                = hdr_out;
    assign m_ip.eth_dest_mac          = '0;
    assign m_ip.eth_src_mac           = '0;
    assign m_ip.eth_type              = '0;
    assign m_ip.ip_payload_axis_tid   = '0;
    assign m_ip.ip_payload_axis_tdest = '0;
    assign o_busy = (state != ST_IDLE) || hdr_out_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            port_cnt <= '0;
            port_q   <= '0;
        end else begin
            state <= state_next;
            if (hdr_fire) begin
                port_q   <= {i_tcp_src, i_tcp_dest};
                port_cnt <= '0;
            end else if (state == ST_PORTS && m_ip.ip_payload_axis_tready) begin
                port_cnt <= port_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_next                   = state;
        s_ip.ip_hdr_ready            = 1'b0;
        s_ip.ip_payload_axis_tready  = 1'b0;
        m_ip.ip_payload_axis_tdata   = '0;
        m_ip.ip_payload_axis_tvalid  = 1'b0;
        m_ip.ip_payload_axis_tlast   = 1'b0;
        m_ip.ip_payload_axis_tuser   = 1'b0;
        case (state)
            ST_IDLE: begin
                s_ip.ip_hdr_ready = hdr_buf_ready;
                if (s_ip.ip_hdr_valid && hdr_buf_ready) begin
                    state_next = ST_PORTS;
                end
            end
            ST_PORTS: begin
                m_ip.ip_payload_axis_tvalid = 1'b1;
                m_ip.ip_payload_axis_tdata  = port_byte(port_q, port_cnt);
                if (m_ip.ip_payload_axis_tready && port_cnt == LAST_PORT_IDX) begin
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // Zero-latency pass-through until the upstream tlast beat.
                m_ip.ip_payload_axis_tdata  = s_ip.ip_payload_axis_tdata;
                m_ip.ip_payload_axis_tvalid = s_ip.ip_payload_axis_tvalid;
                m_ip.ip_payload_axis_tlast  = s_ip.ip_payload_axis_tlast;
                m_ip.ip_payload_axis_tuser  = s_ip.ip_payload_axis_tuser;
                s_ip.ip_payload_axis_tready = m_ip.ip_payload_axis_tready;
                if (s_ip.ip_payload_axis_tvalid && m_ip.ip_payload_axis_tready
                        && s_ip.ip_payload_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
